// File: rtl/retire_trace_sink.sv
// Retirement trace sink: buffers retire records in a drop-on-full FIFO and
// serializes each one as a framed little-endian byte packet.
module retire_trace_sink #(
  parameter int         DEPTH = 8,
  parameter logic [7:0] SYNC  = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        retire_valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic [4:0]  reg_addr_i,
  input  logic [31:0] reg_data_i,
  input  logic        mem_wrt_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o,
  output logic        out_last_o,
  input  logic        out_ready_i,
  output logic        overflow_o,
  output logic [15:0] drop_count_o
);

  localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        mem_wrt;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
  } rec_t;

  typedef enum logic [2:0] {IDLE, HDR, FLG, PC, IR, RD, MA, MD} state_t;

  rec_t          mem [DEPTH];
  rec_t          rec_in;
  rec_t          shadow;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty, push, pop, drop, fire;
  logic          drop_flag, pending_drop;
  state_t        state, next_state;
  logic [1:0]    idx, next_idx;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  assign rec_in      = {pc_i, instr_i, reg_addr_i, reg_data_i, mem_wrt_i, mem_addr_i, mem_data_i};
  assign fifo_empty  = (count == '0);
  assign out_valid_o = (state != IDLE);
  assign fire        = out_valid_o & out_ready_i;
  // A pop at full frees a slot on the same edge, so the retire still fits.
  assign pop         = !fifo_empty && ((state == IDLE) || (fire && out_last_o));
  assign push        = retire_valid_i && ((count != FULL) || pop);
  assign drop        = retire_valid_i && !push;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage array has no reset; count/pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o   <= 1'b0;
      drop_count_o <= '0;
      pending_drop <= 1'b0;
    end else begin
      if (drop) begin
        overflow_o   <= 1'b1;
        pending_drop <= 1'b1;
        if (drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
      end else if (pop) begin
        pending_drop <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow    <= '0;
      drop_flag <= 1'b0;
      state     <= IDLE;
      idx       <= '0;
    end else begin
      if (pop) begin
        shadow    <= mem[rd_ptr];
        drop_flag <= pending_drop;
      end
      state <= next_state;
      idx   <= next_idx;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    case (state)
      IDLE: if (!fifo_empty) next_state = HDR;
      HDR:  if (fire) next_state = FLG;
      FLG:  if (fire) begin
        next_state = PC;
        next_idx   = '0;
      end
      PC, IR, RD, MA, MD: if (fire) begin
        if (idx == 2'd3) begin
          next_idx = '0;
          case (state)
            PC:      next_state = IR;
            IR:      next_state = RD;
            RD:      next_state = shadow.mem_wrt ? MA : (fifo_empty ? IDLE : HDR);
            MA:      next_state = MD;
            default: next_state = fifo_empty ? IDLE : HDR;
          endcase
        end else begin
          next_idx = idx + 2'd1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    out_data_o = 8'h00;
    out_last_o = 1'b0;
    case (state)
      HDR: out_data_o = SYNC;
      FLG: out_data_o = {shadow.mem_wrt, drop_flag, shadow.reg_addr, 1'b0};
      PC:  out_data_o = byte_of(shadow.pc, idx);
      IR:  out_data_o = byte_of(shadow.instr, idx);
      RD: begin
        out_data_o = byte_of(shadow.reg_data, idx);
        out_last_o = (idx == 2'd3) && !shadow.mem_wrt;
      end
      MA:  out_data_o = byte_of(shadow.mem_addr, idx);
      MD: begin
        out_data_o = byte_of(shadow.mem_data, idx);
        out_last_o = (idx == 2'd3);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_retire_trace_sink.sv
// Scoreboard bench for retire_trace_sink: stimulus pushes expected packet bytes,
// a negedge monitor pops and compares every accepted byte.
module tb_retire_trace_sink;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        retire_valid = 1'b0;
  logic [31:0] pc = '0, instr = '0, reg_data = '0, mem_addr = '0, mem_data = '0;
  logic [4:0]  reg_addr = '0;
  logic        mem_wrt = 1'b0;
  logic        out_valid, out_last, out_ready, overflow;
  logic [7:0]  out_data;
  logic [15:0] drop_count;

  retire_trace_sink #(.DEPTH(DEPTH), .SYNC(8'hA5)) dut (
    .clk_i(clk), .rst_i(rst), .retire_valid_i(retire_valid),
    .pc_i(pc), .instr_i(instr), .reg_addr_i(reg_addr), .reg_data_i(reg_data),
    .mem_wrt_i(mem_wrt), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
    .out_ready_i(out_ready), .overflow_o(overflow), .drop_count_o(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        mem_wrt;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
  } tb_rec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0, n_fail = 0;
  int   pkts_issued = 0, pkts_done = 0, pkts_abandoned = 0;
  int   rdy_mode = 0;  // 0 low, 1 high, 2 random

  logic [7:0] vec_alu [22] = '{8'hA5, 8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00,
                               8'h50, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] vec_st  [22] = '{8'hA5, 8'h80, 8'h14, 8'h00, 8'h00, 8'h00, 8'h23, 8'h20,
                               8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00,
                               8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic int outstanding();
    return pkts_issued - pkts_done - pkts_abandoned;
  endfunction

  function automatic tb_rec_t mk_rec(input int i);
    tb_rec_t r;
    r.pc       = 32'h0000_1000 + 32'(i) * 32'd4;
    r.instr    = 32'h0000_0013 ^ (32'(i) << 7) ^ (32'(i) << 20);
    r.reg_addr = 5'(i);
    r.reg_data = 32'hA500_0000 + 32'(i) * 32'h0001_0203;
    r.mem_wrt  = (i % 3) == 0;
    r.mem_addr = 32'h0000_2000 + 32'(i) * 32'd8;
    r.mem_data = ~(32'(i) * 32'h1111_1111);
    return r;
  endfunction

  task automatic push_pkt(input tb_rec_t r, input logic df);
    logic [7:0] b [$];
    exp_t e;
    b.push_back(8'hA5);
    b.push_back({r.mem_wrt, df, r.reg_addr, 1'b0});
    for (int k = 0; k < 4; k++) b.push_back(8'(r.pc >> (8 * k)));
    for (int k = 0; k < 4; k++) b.push_back(8'(r.instr >> (8 * k)));
    for (int k = 0; k < 4; k++) b.push_back(8'(r.reg_data >> (8 * k)));
    if (r.mem_wrt) begin
      for (int k = 0; k < 4; k++) b.push_back(8'(r.mem_addr >> (8 * k)));
      for (int k = 0; k < 4; k++) b.push_back(8'(r.mem_data >> (8 * k)));
    end
    for (int k = 0; k < b.size(); k++) begin
      e.data = b[k];
      e.last = (k == b.size() - 1);
      sb_q.push_back(e);
    end
    pkts_issued++;
  endtask

  task automatic push_lit(input logic [7:0] v [22], input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.data = v[k];
      e.last = (k == n - 1);
      sb_q.push_back(e);
    end
    pkts_issued++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rec(input tb_rec_t r);
    retire_valid = 1'b1;
    pc = r.pc; instr = r.instr; reg_addr = r.reg_addr; reg_data = r.reg_data;
    mem_wrt = r.mem_wrt; mem_addr = r.mem_addr; mem_data = r.mem_data;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((outstanding() != 0 || out_valid) && c < 4000) begin
      tick();
      c++;
    end
    check("idle_reached", 32'(c < 4000), 32'd1);
  endtask

  task automatic wait_room();
    int c = 0;
    while (outstanding() >= DEPTH && c < 4000) begin
      tick();
      c++;
    end
    check("room_reached", 32'(c < 4000), 32'd1);
  endtask

  // Ready driver: sole writer of out_ready.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares accepted bytes against the scoreboard and checks hold stability.
  logic       stall_prev = 1'b0;
  logic [7:0] held = '0;
  int         pos = 0;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      pos        = 0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte (t=%0t)", out_data, $time);
        end else begin
          mon_e = sb_q.pop_front();
          check($sformatf("pkt%0d_byte%0d_data", pkts_done, pos), 32'(out_data), 32'(mon_e.data));
          check($sformatf("pkt%0d_byte%0d_last", pkts_done, pos), 32'(out_last), 32'(mon_e.last));
        end
        pos++;
        if (out_last) begin
          pkts_done++;
          pos = 0;
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tb_rec_t r;
    logic    found;
    int      c;

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0;
    rdy_mode = 1;
    tick(); tick();

    // Single ALU retire, latency check
    r = '0;
    r.pc = 32'h0000_0010; r.instr = 32'h0050_0093; r.reg_addr = 5'd1; r.reg_data = 32'd5;
    drive_rec(r);
    push_lit(vec_alu, 14);
    tick();
    retire_valid = 1'b0;
    check("lat_capture_edge_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_pop_edge_valid", 32'(out_valid), 32'd1);
    check("lat_pop_edge_sync", 32'(out_data), 32'hA5);
    wait_idle();

    // Store retire, 22 bytes
    r = '0;
    r.pc = 32'h0000_0014; r.instr = 32'h0011_2023; r.mem_wrt = 1'b1;
    r.mem_addr = 32'h0000_0040; r.mem_data = 32'hDEAD_BEEF;
    drive_rec(r);
    push_lit(vec_st, 22);
    tick();
    retire_valid = 1'b0;
    wait_idle();

    // 50 mixed records with random ready, paced to never overflow
    rdy_mode = 2;
    for (int i = 0; i < 50; i++) begin
      wait_room();
      r = mk_rec(i);
      drive_rec(r);
      push_pkt(r, 1'b0);
      tick();
      retire_valid = 1'b0;
    end
    wait_idle();
    check("mixed_no_drop", 32'(drop_count), 32'd0);

    // Burst of DEPTH+3 with ready low: recs 0..8 kept, 9 and 10 dropped
    rdy_mode = 0;
    tick(); tick();
    for (int i = 0; i < DEPTH + 3; i++) begin
      r = mk_rec(100 + i);
      drive_rec(r);
      // rec1 follows the burst drops; rec2 follows the drop planned below
      if (i <= DEPTH) push_pkt(r, (i == 1) || (i == 2));
      tick();
    end
    retire_valid = 1'b0;
    tick();
    check("burst_drop_count", 32'(drop_count), 32'd2);
    check("burst_overflow", 32'(overflow), 32'd1);
    check("burst_stalled_valid", 32'(out_valid), 32'd1);
    check("burst_stalled_sync", 32'(out_data), 32'hA5);

    // Full FIFO: retire on the same edge as the pop is accepted
    rdy_mode = 1;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid && out_last && out_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("full_last_byte_seen", 32'(found), 32'd1);
    r = mk_rec(200);
    drive_rec(r);
    push_pkt(r, 1'b0);
    @(posedge clk);
    #1;
    check("full_pop_push_no_drop", 32'(drop_count), 32'd2);
    r = mk_rec(201);  // FIFO still holds DEPTH entries, so this one drops
    drive_rec(r);
    tick();
    retire_valid = 1'b0;
    check("full_next_edge_drop", 32'(drop_count), 32'd3);
    check("full_overflow_sticky", 32'(overflow), 32'd1);
    wait_idle();

    // Reset during byte 7 of a packet
    tick();
    r = mk_rec(300);
    r.mem_wrt = 1'b0;
    drive_rec(r);
    push_pkt(r, 1'b0);
    tick();
    retire_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 10) begin
      tick();
      c++;
    end
    check("rst_pkt_started", 32'(out_valid), 32'd1);
    repeat (6) tick();
    check("byte7_before_reset", 32'(out_data), 32'(r.instr[7:0]));
    rst = 1'b1;
    sb_q.delete();
    pkts_abandoned++;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_last", 32'(out_last), 32'd0);
    check("midrst_data", 32'(out_data), 32'h00);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_drop_count", 32'(drop_count), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check("post_rst_idle", 32'(out_valid), 32'd0);
    r = mk_rec(301);
    drive_rec(r);
    push_pkt(r, 1'b0);
    tick();
    retire_valid = 1'b0;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_sync", 32'(out_data), 32'hA5);
    wait_idle();
    check("post_rst_drop_count", 32'(drop_count), 32'd0);

    tick(); tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
